// File: rtl/seg_scan_driver_if.sv
// Bus between the timer datapath and the 7-segment scanner.
// The master drives the display content; the slave (the scanner) returns the pin drive.
interface seg_scan_driver_if #(
    parameter int DIGITS   = 8,
    parameter int BRIGHT_W = 4
);
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   dot;
    logic [DIGITS-1:0]   blink;
    logic [DIGITS-1:0]   blank;
    logic [BRIGHT_W-1:0] brightness;
    logic [7:0]          seg;
    logic [DIGITS-1:0]   an;
    logic                frame_tick;

    modport master (
        output digits, dot, blink, blank, brightness,
        input  seg, an, frame_tick
    );

    modport slave (
        input  digits, dot, blink, blank, brightness,
        output seg, an, frame_tick
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment scanner with a frame-synchronous input
// snapshot, an inter-digit ghosting guard, PWM brightness, a blink and blank
// mask per digit, and selectable pin polarity. Every output is registered.
module seg_scan_driver #(
    parameter int DIGITS         = 8,
    parameter int SCAN_LOG2      = 13,
    parameter int GUARD          = 64,
    parameter int BRIGHT_W       = 4,
    parameter int BLINK_DIV      = 25000000,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    seg_scan_driver_if.slave  bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BC_W  = $clog2(BLINK_DIV);
    localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;

    logic [SCAN_LOG2-1:0]    r_div_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [BC_W-1:0]         r_blink_cnt;
    logic                    r_blink_phase;
    logic                    r_primed;
    logic [DIGITS-1:0][3:0]  r_sh_digits;
    logic [DIGITS-1:0]       r_sh_dot;
    logic [DIGITS-1:0]       r_sh_blink;
    logic [DIGITS-1:0]       r_sh_blank;
    logic [BRIGHT_W-1:0]     r_sh_bright;
    logic [7:0]              r_seg;
    logic [DIGITS-1:0]       r_an;
    logic                    r_frame_tick;

    logic                    w_slot_end;
    logic                    w_last_idx;
    logic                    w_frame_end;
    logic                    w_load;
    logic [BRIGHT_W-1:0]     w_phase;
    logic                    w_lit;
    logic [7:0]              w_seg_hi;
    logic [DIGITS-1:0]       w_onehot;

    // Active-high g..a glyphs for hex digits, including the A-F letters.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;  default: glyph = 7'h71;
        endcase
    endfunction

    assign w_slot_end  = &r_div_cnt;
    assign w_last_idx  = (r_idx == IDX_W'(DIGITS - 1));
    assign w_frame_end = w_slot_end && w_last_idx;
    assign w_load      = !r_primed || w_frame_end;
    // Upper bits of the slot counter act as the PWM ramp within each slot.
    assign w_phase     = r_div_cnt[SCAN_LOG2-1 -: BRIGHT_W];
    // Blank wins over blink; the guard window keeps anodes off while segments change.
    assign w_lit       = (r_div_cnt >= SCAN_LOG2'(GUARD))
                      && (w_phase <= r_sh_bright)
                      && !r_sh_blank[r_idx]
                      && !(r_sh_blink[r_idx] && !r_blink_phase);
    assign w_seg_hi    = {r_sh_dot[r_idx], glyph(r_sh_digits[r_idx])};
    assign w_onehot    = DIGITS'(1) << r_idx;

    // Slot divider and digit index; the index wraps at the last digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_idx     <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + SCAN_LOG2'(1);
            if (w_slot_end)
                r_idx <= w_last_idx ? '0 : r_idx + IDX_W'(1);
        end
    end

    // Free-running blink timer, deliberately not tied to the frame cadence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (r_blink_cnt == BC_W'(BLINK_DIV - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= !r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + BC_W'(1);
        end
    end

    // Shadow copy of the display inputs, refreshed only at frame boundaries so a frame never tears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_primed    <= 1'b0;
            r_sh_digits <= '0;
            r_sh_dot    <= '0;
            r_sh_blink  <= '0;
            r_sh_blank  <= '1;
            r_sh_bright <= '0;
        end else if (w_load) begin
            r_primed    <= 1'b1;
            r_sh_digits <= bus.digits;
            r_sh_dot    <= bus.dot;
            r_sh_blink  <= bus.blink;
            r_sh_blank  <= bus.blank;
            r_sh_bright <= bus.brightness;
        end
    end

    // Registered pin drive: at most one anode is ever enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_end;
            if (w_lit) begin
                r_an  <= AN_ACTIVE_LOW ? ~w_onehot : w_onehot;
                r_seg <= SEG_ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
            end else begin
                r_an  <= AN_OFF;
                r_seg <= SEG_OFF;
            end
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: DIGITS=4, 16-cycle slots, guard 2,
// 2-bit brightness, 64-cycle blink half-period, active-low pins.
// Timeline note: after the k-th clock edge following reset release the
// outputs reflect the state at count k-1, so one frame spans 64 edges.
module tb_seg_scan_driver;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    seg_scan_driver_if #(.DIGITS(4), .BRIGHT_W(2)) bus ();

    seg_scan_driver #(
        .DIGITS(4), .SCAN_LOG2(4), .GUARD(2), .BRIGHT_W(2),
        .BLINK_DIV(64), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after edge k (edges counted from reset release).
    task automatic goto(input int k);
        while (cyc < k) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] ean, input logic [7:0] eseg);
        checks++;
        assert ({bus.an, bus.seg} === {ean, eseg})
        else begin
            errors++;
            $error("FAIL %s @edge %0d: an=%b seg=%h, expected an=%b seg=%h",
                   tag, cyc, bus.an, bus.seg, ean, eseg);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s @edge %0d: got %b, expected %b", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.digits     = 16'h3210;
        bus.brightness = 2'd3;
        bus.dot        = 4'b0000;
        bus.blink      = 4'b0000;
        bus.blank      = 4'b0000;

        // Reset state, before any clock edge.
        #2;
        chk("reset_out", 4'b1111, 8'hFF);
        chk_bit("reset_tick", bus.frame_tick, 1'b0);
        #10;
        reset = 1'b0;
        cyc   = 0;

        // Frame 0, slot 0: guard at div 0..1, digit 0 lit at div 2..15.
        for (int d = 0; d < 16; d++) begin
            goto(d + 1);
            if (d >= 2) chk("slot0_lit", 4'b1110, 8'hC0);
            else        chk("slot0_guard", 4'b1111, 8'hFF);
        end
        goto(18); chk("slot1_guard", 4'b1111, 8'hFF);
        goto(19); chk("slot1_lit", 4'b1101, 8'hF9);
        goto(32); chk("slot1_end", 4'b1101, 8'hF9);
        goto(40); bus.brightness = 2'd0;
        goto(63); chk_bit("tick_pre", bus.frame_tick, 1'b0);
        goto(64); chk_bit("tick_pulse", bus.frame_tick, 1'b1);
        goto(65); chk_bit("tick_post", bus.frame_tick, 1'b0);

        // Frame 1: brightness 0 -> lit only at div 2..3.
        for (int d = 0; d < 16; d++) begin
            goto(65 + d);
            if (d >= 2 && d <= 3) chk("bright0_lit", 4'b1110, 8'hC0);
            else                  chk("bright0_dark", 4'b1111, 8'hFF);
        end
        bus.brightness = 2'd1;

        // Frame 2: brightness 1 -> lit at div 2..7.
        for (int d = 0; d < 16; d++) begin
            goto(129 + d);
            if (d >= 2 && d <= 7) chk("bright1_lit", 4'b1110, 8'hC0);
            else                  chk("bright1_dark", 4'b1111, 8'hFF);
        end
        bus.brightness = 2'd3;

        // Frame 3: change digits mid-frame at idx 1; old glyphs hold until frame end.
        goto(215); bus.digits = 16'hFEDC;
        goto(220); chk("snap_slot1", 4'b1101, 8'hF9);
        goto(227); chk("snap_slot2", 4'b1011, 8'hA4);
        goto(243); chk("snap_slot3", 4'b0111, 8'hB0);
        goto(245); bus.blink = 4'b0010;
        goto(256); chk_bit("snap_tick", bus.frame_tick, 1'b1);
        goto(259); chk("snap_new0", 4'b1110, 8'hC6);

        // Blink on digit 1: visible in even 64-count windows, dark in odd ones.
        goto(275); chk("blink_vis", 4'b1101, 8'hA1);
        goto(323); chk("blink_other", 4'b1110, 8'hC6);
        goto(339); chk("blink_dark", 4'b1111, 8'hFF);
        goto(403); chk("blink_vis2", 4'b1101, 8'hA1);
        bus.blank = 4'b1000;
        bus.blink = 4'b1000;
        bus.dot   = 4'b0001;

        // Frame 8 (blink-visible window): digit 3 stays dark, dp only on digit 0.
        for (int k = 513; k <= 576; k++) begin
            goto(k);
            chk_bit("blank_an3", bus.an[3], 1'b1);
            chk_bit("dot_only_d0", !bus.seg[7], bus.an == 4'b1110);
        end
        // Spot values in the same frame are taken in order below the loop bound.

        // Frame 9: async reset at idx 2, div 9.
        goto(617); chk("pre_reset", 4'b1011, 8'h86);
        #1 reset = 1'b1;
        #1;
        chk("async_reset", 4'b1111, 8'hFF);
        chk_bit("async_tick", bus.frame_tick, 1'b0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        cyc = 0;
        goto(1); chk("restart_g0", 4'b1111, 8'hFF);
        goto(2); chk("restart_g1", 4'b1111, 8'hFF);
        goto(3); chk("restart_lit", 4'b1110, 8'h46);
        goto(19); chk("restart_slot1", 4'b1101, 8'hA1);
        goto(51); chk("restart_blank3", 4'b1111, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Parametrised multiplexed 7-segment scanner that drives DIGITS common-anode digits from packed hex inputs. It adds features the first-generation scanner lacked:
- frame-synchronous input snapshot (no tearing)
- inter-digit ghosting guard
- PWM brightness control
- per-digit blank mask
- correct A–F glyphs
- selectable output polarity

It sits between the clock/timer datapath and the board display pins.

Parameters:
DIGITS, 8, number of multiplexed digits (1..16)
SCAN_LOG2, 13, log2 of clk cycles per digit slot (slot = 2^SCAN_LOG2 cycles)
GUARD, 64, cycles at start of each slot with all anodes inactive (GUARD < 2^SCAN_LOG2)
BRIGHT_W, 4, brightness width (BRIGHT_W <= SCAN_LOG2)
BLINK_DIV, 25000000, clk cycles per blink half-period (>= 2)
AN_ACTIVE_LOW, 1, 1 = anode enable driven low
SEG_ACTIVE_LOW, 1, 1 = segment/dp lit driven low

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
digits  in  4*DIGITS  hex value per digit; digit i = digits[4i+3:4i]
dot  in  DIGITS  1 = decimal point lit on digit i
blink  in  DIGITS  1 = digit i blinks
blank  in  DIGITS  1 = digit i dark for whole slot
brightness  in  BRIGHT_W  duty level; 0 = dimmest, all-ones = full
seg  out  8  seg[6:0] = g..a, seg[7] = dp, polarity per SEG_ACTIVE_LOW
an  out  DIGITS  anode enables, polarity per AN_ACTIVE_LOW
frame_tick  out  1  one-cycle pulse at end of each full frame

Behaviour:
- Reset (async, active-high):
  - div_cnt=0, idx=0, blink_cnt=0, blink_phase=1 (visible), primed=0.
  - Shadow regs cleared; shadow blank = all ones.
  - an = all inactive, seg = all off (per polarity), frame_tick=0.
  - All outputs are registered and take reset values immediately, without a clock edge.
- Slot counter:
  - div_cnt (SCAN_LOG2 bits) increments every cycle and wraps naturally.
  - When div_cnt = all-ones, idx advances; idx wraps from DIGITS-1 to 0.
  - frame_end = (div_cnt all-ones && idx==DIGITS-1).
  - frame_tick is registered: it equals 1 on the cycle after frame_end.
- Snapshot:
  - load = !primed || frame_end.
  - On load, shadow regs capture digits/dot/blink/blank/brightness, and primed is set.
  - The first load occurs on the first clk edge after reset release.
  - Input changes mid-frame are invisible until the next frame starts.
- Lit condition for the current slot (combinational, then registered):
  - lit = (div_cnt >= GUARD) && (phase <= sh_brightness) && !sh_blank[idx] && !(sh_blink[idx] && !blink_phase)
  - phase = div_cnt[SCAN_LOG2-1 -: BRIGHT_W].
- Outputs, one-cycle latency from div_cnt/idx:
  - If lit: an has only bit idx active; seg = glyph(sh_digit[idx]) plus dp = sh_dot[idx].
  - Else: an all inactive and seg all off.
  - At most one anode is ever active.
- Glyphs, active-high g..a:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Inverted when SEG_ACTIVE_LOW.
- Blink timer:
  - blink_cnt counts 0..BLINK_DIV-1 and is free-running, independent of frames.
  - At BLINK_DIV-1 it wraps to 0 and blink_phase toggles.
- Boundary cases:
  - DIGITS=1: idx stays 0 and frame_end fires every slot.
  - brightness all-ones: lit for all non-guard cycles.
  - Simultaneous blink and blank on a digit: blank dominates (dark).
- Reset mid-operation: outputs go inactive asynchronously. On release the scan restarts at idx 0, div_cnt 0, and a fresh snapshot is taken.

Test Plan:
Bench params: DIGITS=4, SCAN_LOG2=4, GUARD=2, BRIGHT_W=2, BLINK_DIV=64, both polarities active-low. Inputs: digits=16'h3210, brightness=3, dot=0, blink=0, blank=0.

1. Reset and basic scan: during reset an=4'b1111 and seg=8'hFF. After release:
   - an=1110, seg=8'hC0 during slot-0 cycles with div_cnt 2..15 (one-cycle delay).
   - Slot 1: an=1101, seg=8'hF9.
   - Guard cycles 0..1 of each slot: an=1111.
2. Brightness: brightness=0 → each digit is lit only at div_cnt 2..3 (2 of 16 cycles). brightness=1 → lit at div_cnt 2..7.
3. Snapshot: change digits to 16'hFEDC mid-frame (idx=1) → old glyphs remain until frame_tick pulses. The next slot 0 then shows seg=~8'h39=8'hC6.
4. Blink: blink=4'b0010 → digit 1 is visible for the first 64 cycles after reset, dark for the next 64, and alternates thereafter. Other digits are unaffected.
5. Blank, dot, precedence: blank=4'b1000 plus blink=4'b1000 → an[3] is never low. dot=4'b0001 → seg[7]=0 only while an=1110.
6. Async reset mid-slot: assert reset at idx=2, div_cnt=9 → an=1111 and seg=8'hFF before any clk edge. After release, idx=0, and digit 0 is first lit 3 cycles later.
